// File: rtl/regist_rs_dispatch_credit_if.sv
// Dispatch bundle interface between the scheduling stage and the
// reservation-station dispatcher. It carries the order bundle, the per-RS
// release counts, the stall back-pressure, the write strobes and the credit status.
interface regist_rs_dispatch_credit_if #(
  parameter int P_ORDERS = 2,
  parameter int P_CNT_W  = 4,
  parameter int P_REL_W  = 2
);
  logic                  iORDER_LOCK;
  logic [P_ORDERS-1:0]   iORDER_VALID;
  logic [3*P_ORDERS-1:0] iORDER_CLASS;
  logic [4*P_REL_W-1:0]  iRS_RELEASE;
  logic                  oSTALL;
  logic [4*P_ORDERS-1:0] oRS_VALID;
  logic [4*P_CNT_W-1:0]  oRS_FREE;
  logic                  oCREDIT_ERR;

  // Upstream side: issues bundles and releases, and observes dispatch results.
  modport master (
    output iORDER_LOCK, iORDER_VALID, iORDER_CLASS, iRS_RELEASE,
    input  oSTALL, oRS_VALID, oRS_FREE, oCREDIT_ERR
  );

  // Dispatcher side.
  modport slave (
    input  iORDER_LOCK, iORDER_VALID, iORDER_CLASS, iRS_RELEASE,
    output oSTALL, oRS_VALID, oRS_FREE, oCREDIT_ERR
  );
endinterface

// File: rtl/regist_rs_dispatch_credit.sv
// Reservation-station dispatcher with credit tracking.
// Routes up to P_ORDERS orders per cycle into four reservation stations:
// RS0 branch, RS1 mul/div plus overflow ALU, RS2 ALU, RS3 load/store.
// A bundle dispatches whole or not at all. Free entries are tracked with
// one credit counter per RS, and ALU orders are balanced between RS1 and RS2
// using credits that are already tentatively consumed within the same bundle.
module regist_rs_dispatch_credit #(
  parameter int P_ORDERS = 2,
  parameter int P_DEPTH  = 8,
  parameter int P_CNT_W  = 4,
  parameter int P_REL_W  = 2
) (
  input logic                        iCLOCK,
  input logic                        inRESET,
  input logic                        iRESET_SYNC,
  regist_rs_dispatch_credit_if.slave bus
);

  localparam int NUM_RS = 4;
  // The tentative arithmetic is signed. It has room for "one below zero" and
  // for "count plus release" before the clamp.
  localparam int TW = ((P_CNT_W > P_REL_W) ? P_CNT_W : P_REL_W) + 2;

  localparam logic [2:0] CLS_BRANCH = 3'd1;
  localparam logic [2:0] CLS_ALU    = 3'd2;
  localparam logic [2:0] CLS_MULDIV = 3'd3;
  localparam logic [2:0] CLS_LDST   = 3'd4;

  localparam logic [1:0] RS_BRANCH = 2'd0;
  localparam logic [1:0] RS_MULALU = 2'd1;
  localparam logic [1:0] RS_ALU    = 2'd2;
  localparam logic [1:0] RS_LDST   = 2'd3;

  localparam logic signed [TW-1:0]  ONE_CREDIT = TW'(1);
  localparam logic signed [TW-1:0]  DEPTH_T    = TW'(P_DEPTH);
  localparam logic [P_CNT_W-1:0]    DEPTH_C    = P_CNT_W'(P_DEPTH);

  // Zero-extend a credit count into the signed tentative domain.
  function automatic logic signed [TW-1:0] widenCnt(input logic [P_CNT_W-1:0] cnt);
    return $signed({{(TW-P_CNT_W){1'b0}}, cnt});
  endfunction

  // Zero-extend a release count into the signed tentative domain.
  function automatic logic signed [TW-1:0] widenRel(input logic [P_REL_W-1:0] rel);
    return $signed({{(TW-P_REL_W){1'b0}}, rel});
  endfunction

  logic [P_CNT_W-1:0]    creditCnt_r [NUM_RS];
  logic [4*P_ORDERS-1:0] rsValid_r;
  logic                  creditErr_r;

  logic signed [TW-1:0]  tentFree_s [NUM_RS];
  logic [4*P_ORDERS-1:0] route_s;
  logic                  fit_s;
  logic                  bundle_s;
  logic                  accept_s;
  logic [P_CNT_W-1:0]    cntNext_s [NUM_RS];
  logic                  overflow_s;

  // Route each order in age order, consuming tentative credits as it goes.
  always_comb begin
    logic [1:0] rsSel;
    logic       takes;
    for (int n = 0; n < NUM_RS; n++) begin
      tentFree_s[n] = widenCnt(creditCnt_r[n]);
    end
    route_s = '0;
    for (int i = 0; i < P_ORDERS; i++) begin
      rsSel = RS_BRANCH;
      takes = 1'b0;
      if (bus.iORDER_VALID[i]) begin
        case (bus.iORDER_CLASS[3*i +: 3])
          CLS_BRANCH: begin
            rsSel = RS_BRANCH;
            takes = 1'b1;
          end
          CLS_ALU: begin
            takes = 1'b1;
            // A tie goes to the dedicated ALU station.
            if (tentFree_s[RS_MULALU] > tentFree_s[RS_ALU]) begin
              rsSel = RS_MULALU;
            end else begin
              rsSel = RS_ALU;
            end
          end
          CLS_MULDIV: begin
            rsSel = RS_MULALU;
            takes = 1'b1;
          end
          CLS_LDST: begin
            rsSel = RS_LDST;
            takes = 1'b1;
          end
          default: begin
            rsSel = RS_BRANCH;
            takes = 1'b0;
          end
        endcase
      end else begin
        takes = 1'b0;
      end
      if (takes) begin
        tentFree_s[rsSel]            = tentFree_s[rsSel] - ONE_CREDIT;
        route_s[4*i + int'(rsSel)]   = 1'b1;
      end else begin
        route_s[4*i + int'(rsSel)]   = 1'b0;
      end
    end
  end

  // The bundle fits only if no station's tentative credit went negative.
  always_comb begin
    fit_s = 1'b1;
    for (int n = 0; n < NUM_RS; n++) begin
      if (tentFree_s[n][TW-1]) begin
        fit_s = 1'b0;
      end else begin
        fit_s = fit_s;
      end
    end
  end

  assign bundle_s = ~bus.iORDER_LOCK & (|bus.iORDER_VALID);
  assign accept_s = bundle_s & fit_s & ~iRESET_SYNC;

  // Next credit per station: dispatch and release both apply; clamp on overflow.
  always_comb begin
    logic signed [TW-1:0] sum;
    overflow_s = 1'b0;
    for (int n = 0; n < NUM_RS; n++) begin
      if (accept_s) begin
        sum = tentFree_s[n];
      end else begin
        sum = widenCnt(creditCnt_r[n]);
      end
      sum = sum + widenRel(bus.iRS_RELEASE[n*P_REL_W +: P_REL_W]);
      if (sum > DEPTH_T) begin
        cntNext_s[n] = DEPTH_C;
        overflow_s   = 1'b1;
      end else begin
        cntNext_s[n] = sum[P_CNT_W-1:0];
      end
    end
  end

  // Credit counters, the registered write strobes and the sticky credit error.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      for (int n = 0; n < NUM_RS; n++) begin
        creditCnt_r[n] <= DEPTH_C;
      end
      rsValid_r   <= '0;
      creditErr_r <= 1'b0;
    end else if (iRESET_SYNC) begin
      for (int n = 0; n < NUM_RS; n++) begin
        creditCnt_r[n] <= DEPTH_C;
      end
      rsValid_r   <= '0;
      creditErr_r <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_RS; n++) begin
        creditCnt_r[n] <= cntNext_s[n];
      end
      rsValid_r   <= accept_s ? route_s : '0;
      creditErr_r <= creditErr_r | overflow_s;
    end
  end

  // Pack the per-station credit counts onto the free-count bus.
  always_comb begin
    bus.oRS_FREE = '0;
    for (int n = 0; n < NUM_RS; n++) begin
      bus.oRS_FREE[n*P_CNT_W +: P_CNT_W] = creditCnt_r[n];
    end
  end

  assign bus.oSTALL      = bundle_s & ~fit_s;
  assign bus.oRS_VALID   = rsValid_r;
  assign bus.oCREDIT_ERR = creditErr_r;

endmodule

// File: tb/tb_regist_rs_dispatch_credit.sv
// Testbench for regist_rs_dispatch_credit: directed scenarios plus randomized
// bundles. A queue-based scoreboard is fed from a reference model that works on
// integer free counts.
module tb_regist_rs_dispatch_credit;
  localparam int P_ORDERS = 2;
  localparam int P_DEPTH  = 8;
  localparam int P_CNT_W  = 4;
  localparam int P_REL_W  = 2;

  logic iCLOCK;
  logic inRESET;
  logic iRESET_SYNC;

  regist_rs_dispatch_credit_if #(.P_ORDERS(P_ORDERS), .P_CNT_W(P_CNT_W), .P_REL_W(P_REL_W)) bus ();

  regist_rs_dispatch_credit #(
    .P_ORDERS(P_ORDERS), .P_DEPTH(P_DEPTH), .P_CNT_W(P_CNT_W), .P_REL_W(P_REL_W)
  ) dut (
    .iCLOCK(iCLOCK),
    .inRESET(inRESET),
    .iRESET_SYNC(iRESET_SYNC),
    .bus(bus)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  typedef struct { int due; logic stall; } stall_exp_t;
  typedef struct { int due; logic [7:0] strobe; logic [15:0] free; logic err; } post_exp_t;

  stall_exp_t stallQ[$];
  post_exp_t  postQ[$];
  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;
  int mFree[4];
  bit mErr;

  always @(posedge iCLOCK) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] packFree();
    logic [15:0] r;
    for (int n = 0; n < 4; n++) r[4*n +: 4] = 4'(mFree[n]);
    return r;
  endfunction

  task automatic modelReset();
    for (int n = 0; n < 4; n++) mFree[n] = P_DEPTH;
    mErr = 1'b0;
  endtask

  // One cycle of stimulus. It is entered just after a rising edge. The model
  // decides the outcome and pushes the expectations into the scoreboard.
  task automatic step(input logic lock, input logic [1:0] valid, input logic [5:0] cls,
                      input logic [7:0] rel, input logic srst);
    int tmp[4];
    logic [7:0] strobe;
    bit fit, stall, accept;
    int rs, c;
    stall_exp_t se;
    post_exp_t pe;
    bus.iORDER_LOCK  = lock;
    bus.iORDER_VALID = valid;
    bus.iORDER_CLASS = cls;
    bus.iRS_RELEASE  = rel;
    iRESET_SYNC      = srst;
    for (int n = 0; n < 4; n++) tmp[n] = mFree[n];
    strobe = 8'h00;
    for (int i = 0; i < 2; i++) begin
      rs = -1;
      if (valid[i]) begin
        c = int'(cls[3*i +: 3]);
        if (c == 1) rs = 0;
        else if (c == 3) rs = 1;
        else if (c == 4) rs = 3;
        else if (c == 2) rs = (tmp[1] > tmp[2]) ? 1 : 2;
      end
      if (rs >= 0) begin
        tmp[rs] = tmp[rs] - 1;
        strobe[4*i + rs] = 1'b1;
      end
    end
    fit = 1'b1;
    for (int n = 0; n < 4; n++) if (tmp[n] < 0) fit = 1'b0;
    stall  = !lock && (valid != 2'b00) && !fit;
    accept = !lock && (valid != 2'b00) && fit && !srst;
    se.due = cyc; se.stall = stall;
    stallQ.push_back(se);
    if (srst) begin
      modelReset();
      strobe = 8'h00;
    end else begin
      if (!accept) strobe = 8'h00;
      for (int n = 0; n < 4; n++) begin
        if (accept) mFree[n] = tmp[n];
        mFree[n] = mFree[n] + int'(rel[2*n +: 2]);
        if (mFree[n] > P_DEPTH) begin
          mFree[n] = P_DEPTH;
          mErr = 1'b1;
        end
      end
    end
    pe.due = cyc + 1; pe.strobe = strobe; pe.free = packFree(); pe.err = mErr;
    postQ.push_back(pe);
    @(posedge iCLOCK);
    #1;
  endtask

  // Monitor: on each falling edge, retire the expectations that fall due this cycle.
  always @(negedge iCLOCK) begin
    stall_exp_t se;
    post_exp_t pe;
    if (inRESET) begin
      if (stallQ.size() > 0 && stallQ[0].due == cyc) begin
        se = stallQ.pop_front();
        check("sb_stall", 32'(bus.oSTALL), 32'(se.stall));
      end
      if (postQ.size() > 0 && postQ[0].due == cyc) begin
        pe = postQ.pop_front();
        check("sb_rs_valid", 32'(bus.oRS_VALID), 32'(pe.strobe));
        check("sb_rs_free", 32'(bus.oRS_FREE), 32'(pe.free));
        check("sb_credit_err", 32'(bus.oCREDIT_ERR), 32'(pe.err));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rel;
    // The bundle is valid during reset and must be discarded.
    inRESET          = 1'b0;
    iRESET_SYNC      = 1'b0;
    bus.iORDER_LOCK  = 1'b0;
    bus.iORDER_VALID = 2'b11;
    bus.iORDER_CLASS = {3'd3, 3'd1};
    bus.iRS_RELEASE  = 8'h00;
    modelReset();
    @(negedge iCLOCK);
    @(negedge iCLOCK);
    check("reset_free", 32'(bus.oRS_FREE), 32'h8888);
    check("reset_valid", 32'(bus.oRS_VALID), 32'h0);
    check("reset_stall", 32'(bus.oSTALL), 32'h0);
    check("reset_err", 32'(bus.oCREDIT_ERR), 32'h0);
    bus.iORDER_VALID = 2'b00;
    inRESET = 1'b1;
    @(posedge iCLOCK);
    #1;

    // Two ALU orders with equal credits: order 0 goes to RS2, order 1 to RS1.
    step(1'b0, 2'b11, {3'd2, 3'd2}, 8'h00, 1'b0);
    check("t2_strobe", 32'(bus.oRS_VALID), 32'h24);
    check("t2_free", 32'(bus.oRS_FREE), 32'h8778);

    // Load/store pressure on RS3, with a release that arrives one cycle late.
    step(1'b0, 2'b00, 6'd0, 8'h00, 1'b1);
    for (int k = 0; k < 7; k++) step(1'b0, 2'b01, {3'd0, 3'd4}, 8'h00, 1'b0);
    check("t3_free_pre", 32'(bus.oRS_FREE[15:12]), 32'h1);
    step(1'b0, 2'b11, {3'd4, 3'd4}, 8'h00, 1'b0);
    check("t3_stall_valid", 32'(bus.oRS_VALID), 32'h0);
    check("t3_stall_free", 32'(bus.oRS_FREE[15:12]), 32'h1);
    step(1'b0, 2'b11, {3'd4, 3'd4}, 8'h40, 1'b0);
    check("t3_rel_valid", 32'(bus.oRS_VALID), 32'h0);
    check("t3_rel_free", 32'(bus.oRS_FREE[15:12]), 32'h2);
    step(1'b0, 2'b11, {3'd4, 3'd4}, 8'h00, 1'b0);
    check("t3_acc_valid", 32'(bus.oRS_VALID), 32'h88);
    check("t3_acc_free", 32'(bus.oRS_FREE[15:12]), 32'h0);

    // A locked bundle produces no strobes and no stall.
    step(1'b1, 2'b11, {3'd3, 3'd1}, 8'h00, 1'b0);
    check("t4_valid", 32'(bus.oRS_VALID), 32'h0);
    check("t4_free", 32'(bus.oRS_FREE), 32'h0888);

    // Dispatch and release on RS0 in the same cycle.
    step(1'b0, 2'b00, 6'd0, 8'h00, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 2'b01, {3'd0, 3'd1}, 8'h00, 1'b0);
    check("t5_free_pre", 32'(bus.oRS_FREE[3:0]), 32'h5);
    step(1'b0, 2'b01, {3'd0, 3'd1}, 8'h02, 1'b0);
    check("t5_valid", 32'(bus.oRS_VALID), 32'h01);
    check("t5_free", 32'(bus.oRS_FREE[3:0]), 32'h6);

    // Over-release clamps the count; the error is sticky until a flush.
    step(1'b0, 2'b00, 6'd0, 8'h00, 1'b1);
    step(1'b0, 2'b00, 6'd0, 8'h10, 1'b0);
    check("t6_free", 32'(bus.oRS_FREE[11:8]), 32'h8);
    check("t6_err", 32'(bus.oCREDIT_ERR), 32'h1);
    step(1'b0, 2'b00, 6'd0, 8'h00, 1'b0);
    check("t6_err_sticky", 32'(bus.oCREDIT_ERR), 32'h1);
    step(1'b0, 2'b00, 6'd0, 8'h00, 1'b1);
    check("t6_err_clear", 32'(bus.oCREDIT_ERR), 32'h0);

    // Randomized bundles, releases, locks and flushes.
    for (int k = 0; k < 600; k++) begin
      for (int n = 0; n < 4; n++)
        rel[2*n +: 2] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      step(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
           {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))}, rel,
           ($urandom_range(0, 49) == 0));
    end

    // Async reset in the middle of a bundle discards it.
    @(negedge iCLOCK);
    #1;
    bus.iORDER_LOCK  = 1'b0;
    bus.iORDER_VALID = 2'b11;
    bus.iORDER_CLASS = {3'd2, 3'd4};
    bus.iRS_RELEASE  = 8'h00;
    iRESET_SYNC      = 1'b0;
    #1;
    inRESET = 1'b0;
    #1;
    check("mid_reset_free", 32'(bus.oRS_FREE), 32'h8888);
    check("mid_reset_valid", 32'(bus.oRS_VALID), 32'h0);
    check("mid_reset_err", 32'(bus.oCREDIT_ERR), 32'h0);
    modelReset();
    bus.iORDER_VALID = 2'b00;
    @(posedge iCLOCK);
    #1;
    check("mid_reset_hold_valid", 32'(bus.oRS_VALID), 32'h0);
    inRESET = 1'b1;
    @(posedge iCLOCK);
    #1;
    step(1'b0, 2'b11, {3'd3, 3'd2}, 8'h00, 1'b0);
    check("post_reset_valid", 32'(bus.oRS_VALID), 32'h24);

    repeat (3) @(posedge iCLOCK);
    #1;
    check("sb_stall_drained", 32'(stallQ.size()), 32'h0);
    check("sb_post_drained", 32'(postQ.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
